// File: rtl/sa_feed_drain_ctrl.sv
// sa_feed_drain_ctrl: feed/flush/drain sequencer for one systolic-array tile.
// Reads N rows from the data and acc registers through 1-entry hold buffers.
// Pumps them through per-lane skew chains into the mesh, flushes it, then
// writes N deskewed result rows to the destination register.
// Mesh timing contract: res_mesh_i lane r carries the result of the skewed
// inputs presented MESH_WIDTH pumps earlier on that lane.
module sa_feed_drain_ctrl #(
    parameter int MESH_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int N_REGS     = 8,
    parameter int ID_WIDTH   = 4,
    localparam int RW        = $clog2(N_REGS),
    localparam int AW        = $clog2(MESH_WIDTH),
    localparam int RLEN      = MESH_WIDTH * DATA_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [RW-1:0]       data_reg_i,
    input  logic [RW-1:0]       acc_reg_i,
    input  logic [RW-1:0]       res_reg_i,
    input  logic [AW:0]         n_rows_i,
    input  logic                zero_acc_i,
    input  logic [ID_WIDTH-1:0] id_i,
    output logic [RW-1:0]       data_raddr_o,
    output logic [AW-1:0]       data_rrowaddr_o,
    input  logic [RLEN-1:0]     data_rdata_i,
    input  logic                data_rvalid_i,
    output logic                data_rready_o,
    output logic                data_rlast_o,
    output logic [RW-1:0]       acc_raddr_o,
    output logic [AW-1:0]       acc_rrowaddr_o,
    input  logic [RLEN-1:0]     acc_rdata_i,
    input  logic                acc_rvalid_i,
    output logic                acc_rready_o,
    output logic                acc_rlast_o,
    output logic [RW-1:0]       res_waddr_o,
    output logic [AW-1:0]       res_wrowaddr_o,
    output logic [RLEN-1:0]     res_wdata_o,
    output logic                res_we_o,
    output logic                res_wlast_o,
    input  logic                res_wready_i,
    output logic [RLEN-1:0]     data_mesh_o,
    output logic [RLEN-1:0]     acc_mesh_o,
    input  logic [RLEN-1:0]     res_mesh_i,
    output logic                pump_o,
    output logic                switch_db_o,
    output logic [ID_WIDTH-1:0] sa_id_o,
    output logic                finished_o,
    output logic [ID_WIDTH-1:0] finished_id_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [AW:0] ONE_C  = (AW+1)'(1);
    localparam logic [AW:0] MW_C   = (AW+1)'(MESH_WIDTH);
    localparam logic [AW:0] MWM1_C = (AW+1)'(MESH_WIDTH - 1);
    localparam logic [AW:0] MWM2_C = (AW+1)'(MESH_WIDTH - 2);

    logic [1:0]          state_q, state_d;
    logic [AW:0]         cnt_q, cnt_d;      // fc in FEED, flush count, d in DRAIN
    logic [AW:0]         drq_q, drq_d;
    logic [AW:0]         arq_q, arq_d;
    logic [AW:0]         n_q, n_d;
    logic [RW-1:0]       data_reg_q, data_reg_d, acc_reg_q, acc_reg_d, res_reg_q, res_reg_d;
    logic                zacc_q, zacc_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [RLEN-1:0]     dhold_q, dhold_d, ahold_q, ahold_d;
    logic                dhold_v_q, dhold_v_d, ahold_v_q, ahold_v_d;

    logic st_feed, st_flush, st_drain, rows_phase, pump_rows, drain_wr;
    logic issue_fire, data_take, acc_take, skew_en, deskew_en;
    logic [AW:0]     n_clamped, n_m1;
    logic [RLEN-1:0] feed_data, feed_acc, deskew_row;

    assign st_feed    = (state_q == S_FEED);
    assign st_flush   = (state_q == S_FLUSH);
    assign st_drain   = (state_q == S_DRAIN);
    assign n_m1       = n_q - ONE_C;
    assign n_clamped  = (n_rows_i == '0 || n_rows_i > MW_C) ? MW_C : n_rows_i;

    assign issue_ready_o = (state_q == S_IDLE);
    assign issue_fire    = issue_valid_i & issue_ready_o & ~rst_i;
    assign switch_db_o   = issue_fire;
    assign sa_id_o       = id_q;
    assign finished_id_o = id_q;

    // A real row is pumped once both holds are full; zero_acc counts as a full acc hold.
    assign rows_phase = st_feed & (cnt_q < n_q);
    assign pump_rows  = rows_phase & dhold_v_q & (zacc_q | ahold_v_q);
    assign drain_wr   = st_drain & (cnt_q < n_q);
    assign pump_o     = pump_rows | (st_feed & ~rows_phase) | st_flush
                      | (st_drain & (~drain_wr | res_wready_i));
    assign finished_o = st_drain & pump_o & (cnt_q == MWM1_C);
    assign skew_en    = pump_o & (st_feed | st_flush);
    assign deskew_en  = pump_o & (st_flush | st_drain);

    // A hold being pumped this cycle is refilled on the same edge, so a steady
    // stream of beats is accepted every cycle.
    assign data_rready_o   = st_feed & (drq_q < n_q) & (~dhold_v_q | pump_rows);
    assign acc_rready_o    = st_feed & ~zacc_q & (arq_q < n_q) & (~ahold_v_q | pump_rows);
    assign data_take       = data_rvalid_i & data_rready_o;
    assign acc_take        = acc_rvalid_i & acc_rready_o;
    assign data_rlast_o    = data_take & (drq_q == n_m1);
    assign acc_rlast_o     = acc_take & (arq_q == n_m1);
    assign data_raddr_o    = st_feed ? data_reg_q : '0;
    assign data_rrowaddr_o = st_feed ? drq_q[AW-1:0] : '0;
    assign acc_raddr_o     = (st_feed & ~zacc_q) ? acc_reg_q : '0;
    assign acc_rrowaddr_o  = (st_feed & ~zacc_q) ? arq_q[AW-1:0] : '0;

    assign res_we_o       = drain_wr;
    assign res_waddr_o    = drain_wr ? res_reg_q : '0;
    assign res_wrowaddr_o = drain_wr ? cnt_q[AW-1:0] : '0;
    assign res_wdata_o    = drain_wr ? deskew_row : '0;
    assign res_wlast_o    = drain_wr & (cnt_q == n_m1);

    // Pad and flush pumps feed zero rows.
    assign feed_data = pump_rows ? dhold_q : '0;
    assign feed_acc  = (pump_rows & ~zacc_q) ? ahold_q : '0;

    // Next-state logic for the sequencer, counters and hold buffers.
    always_comb begin
        // NOTE: every _d takes its _q value first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        drq_d      = drq_q;
        arq_d      = arq_q;
        n_d        = n_q;
        data_reg_d = data_reg_q;
        acc_reg_d  = acc_reg_q;
        res_reg_d  = res_reg_q;
        zacc_d     = zacc_q;
        id_d       = id_q;
        dhold_d    = dhold_q;
        dhold_v_d  = dhold_v_q;
        ahold_d    = ahold_q;
        ahold_v_d  = ahold_v_q;
        case (state_q)
            S_IDLE: if (issue_fire) begin
                state_d    = S_FEED;
                cnt_d      = '0;
                drq_d      = '0;
                arq_d      = '0;
                n_d        = n_clamped;
                data_reg_d = data_reg_i;
                acc_reg_d  = acc_reg_i;
                res_reg_d  = res_reg_i;
                zacc_d     = zero_acc_i;
                id_d       = id_i;
            end
            S_FEED: if (pump_o) begin
                if (cnt_q == MWM1_C) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_FLUSH: begin
                if (cnt_q == MWM2_C) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            S_DRAIN: if (pump_o) begin
                if (cnt_q == MWM1_C) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (data_take) begin
            dhold_d   = data_rdata_i;
            dhold_v_d = 1'b1;
            drq_d     = drq_q + ONE_C;
        end else if (pump_rows) begin
            dhold_d   = '0;
            dhold_v_d = 1'b0;
        end
        if (acc_take) begin
            ahold_d   = acc_rdata_i;
            ahold_v_d = 1'b1;
            arq_d     = arq_q + ONE_C;
        end else if (pump_rows) begin
            ahold_d   = '0;
            ahold_v_d = 1'b0;
        end
    end

    // Control and hold registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drq_q      <= '0;
            arq_q      <= '0;
            n_q        <= '0;
            data_reg_q <= '0;
            acc_reg_q  <= '0;
            res_reg_q  <= '0;
            zacc_q     <= 1'b0;
            id_q       <= '0;
            dhold_q    <= '0;
            dhold_v_q  <= 1'b0;
            ahold_q    <= '0;
            ahold_v_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drq_q      <= drq_d;
            arq_q      <= arq_d;
            n_q        <= n_d;
            data_reg_q <= data_reg_d;
            acc_reg_q  <= acc_reg_d;
            res_reg_q  <= res_reg_d;
            zacc_q     <= zacc_d;
            id_q       <= id_d;
            dhold_q    <= dhold_d;
            dhold_v_q  <= dhold_v_d;
            ahold_q    <= ahold_d;
            ahold_v_q  <= ahold_v_d;
        end
    end

    // Skewer: lane 0 passes straight through, lane r is delayed r pumps.
    assign data_mesh_o[0 +: DATA_WIDTH] = feed_data[0 +: DATA_WIDTH];
    assign acc_mesh_o[0 +: DATA_WIDTH]  = feed_acc[0 +: DATA_WIDTH];
    for (genvar gl = 1; gl < MESH_WIDTH; gl++) begin : g_skew
        logic [DATA_WIDTH-1:0] d_sk_q [gl];
        logic [DATA_WIDTH-1:0] a_sk_q [gl];
        // Shift this lane's delay chain on every FEED/FLUSH pump.
        always_ff @(posedge clk_i) begin
            // NOTE: skew chains are reset so an abandoned tile leaves no stale rows on the mesh inputs.
            if (rst_i) begin
                for (int k = 0; k < gl; k++) begin
                    d_sk_q[k] <= '0;
                    a_sk_q[k] <= '0;
                end
            end else if (skew_en) begin
                d_sk_q[0] <= feed_data[gl*DATA_WIDTH +: DATA_WIDTH];
                a_sk_q[0] <= feed_acc[gl*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k < gl; k++) begin
                    d_sk_q[k] <= d_sk_q[k-1];
                    a_sk_q[k] <= a_sk_q[k-1];
                end
            end
        end
        assign data_mesh_o[gl*DATA_WIDTH +: DATA_WIDTH] = d_sk_q[gl-1];
        assign acc_mesh_o[gl*DATA_WIDTH +: DATA_WIDTH]  = a_sk_q[gl-1];
    end

    // Deskewer: lane r is delayed MESH_WIDTH-1-r pumps; the last lane is direct.
    assign deskew_row[(MESH_WIDTH-1)*DATA_WIDTH +: DATA_WIDTH] =
        res_mesh_i[(MESH_WIDTH-1)*DATA_WIDTH +: DATA_WIDTH];
    for (genvar gl = 0; gl < MESH_WIDTH - 1; gl++) begin : g_deskew
        localparam int DEPTH = MESH_WIDTH - 1 - gl;
        logic [DATA_WIDTH-1:0] r_sk_q [DEPTH];
        // Shift this lane's result chain on every FLUSH/DRAIN pump.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int k = 0; k < DEPTH; k++) r_sk_q[k] <= '0;
            end else if (deskew_en) begin
                r_sk_q[0] <= res_mesh_i[gl*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k < DEPTH; k++) r_sk_q[k] <= r_sk_q[k-1];
            end
        end
        assign deskew_row[gl*DATA_WIDTH +: DATA_WIDTH] = r_sk_q[DEPTH-1];
    end

endmodule

// File: tb/tb_sa_feed_drain_ctrl.sv
// tb_sa_feed_drain_ctrl: directed bench for sa_feed_drain_ctrl (MESH_WIDTH=4).
// The bench owns a register-file model serving the read/write ports and a mesh
// model that multiplies data and acc lanes elementwise with a 4-pump latency.
module tb_sa_feed_drain_ctrl;

    localparam int MW = 4;
    localparam int DW = 32;
    localparam int RL = MW * DW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          issue_valid_i = 1'b0;
    logic          issue_ready_o;
    logic [2:0]    data_reg_i = '0, acc_reg_i = '0, res_reg_i = '0;
    logic [2:0]    n_rows_i = '0;
    logic          zero_acc_i = 1'b0;
    logic [3:0]    id_i = '0;
    logic [2:0]    data_raddr_o, acc_raddr_o, res_waddr_o;
    logic [1:0]    data_rrowaddr_o, acc_rrowaddr_o, res_wrowaddr_o;
    logic [RL-1:0] data_rdata_i, acc_rdata_i, res_wdata_o, data_mesh_o, acc_mesh_o, res_mesh_i;
    logic          data_rvalid_i = 1'b0, acc_rvalid_i = 1'b0, res_wready_i = 1'b1;
    logic          data_rready_o, data_rlast_o, acc_rready_o, acc_rlast_o;
    logic          res_we_o, res_wlast_o, pump_o, switch_db_o, finished_o;
    logic [3:0]    sa_id_o, finished_id_o;

    sa_feed_drain_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .data_reg_i(data_reg_i), .acc_reg_i(acc_reg_i), .res_reg_i(res_reg_i),
        .n_rows_i(n_rows_i), .zero_acc_i(zero_acc_i), .id_i(id_i),
        .data_raddr_o(data_raddr_o), .data_rrowaddr_o(data_rrowaddr_o),
        .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i),
        .data_rready_o(data_rready_o), .data_rlast_o(data_rlast_o),
        .acc_raddr_o(acc_raddr_o), .acc_rrowaddr_o(acc_rrowaddr_o),
        .acc_rdata_i(acc_rdata_i), .acc_rvalid_i(acc_rvalid_i),
        .acc_rready_o(acc_rready_o), .acc_rlast_o(acc_rlast_o),
        .res_waddr_o(res_waddr_o), .res_wrowaddr_o(res_wrowaddr_o),
        .res_wdata_o(res_wdata_o), .res_we_o(res_we_o), .res_wlast_o(res_wlast_o),
        .res_wready_i(res_wready_i),
        .data_mesh_o(data_mesh_o), .acc_mesh_o(acc_mesh_o), .res_mesh_i(res_mesh_i),
        .pump_o(pump_o), .switch_db_o(switch_db_o), .sa_id_o(sa_id_o),
        .finished_o(finished_o), .finished_id_o(finished_id_o)
    );

    always #5 clk_i = ~clk_i;

    logic [RL-1:0] rf [8][MW];
    logic [RL-1:0] mpipe [MW];
    assign data_rdata_i = rf[data_raddr_o][data_rrowaddr_o];
    assign acc_rdata_i  = rf[acc_raddr_o][acc_rrowaddr_o];
    assign res_mesh_i   = mpipe[MW-1];

    int n_checks = 0, n_pass = 0;
    int cyc, dk, ak, n_exp, stall_row, stall_len;
    bit zacc_t;
    int d_off [MW];
    int a_off [MW];
    int pumps, data_reads, acc_reads, acc_stalls, acc_ready_seen, writes, wlast_row, wlast_err;
    int fin_cnt, fin_cyc, sw_cnt, stall_cnt, stall_pump_err, stall_err;
    logic [3:0]    fin_id;
    logic [RL-1:0] stall_wd;

    task automatic check(input string tag, input logic [RL-1:0] obs, input logic [RL-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [RL-1:0] prod_row(input logic [RL-1:0] a, input logic [RL-1:0] b);
        logic [RL-1:0] r;
        r = '0;
        for (int l = 0; l < MW; l++) r[l*DW +: DW] = a[l*DW +: DW] * b[l*DW +: DW];
        return r;
    endfunction

    function automatic logic [RL-1:0] sentinel(input int row);
        logic [RL-1:0] r;
        for (int l = 0; l < MW; l++) r[l*DW +: DW] = 32'hA5A5_0000 + 32'(row * 16 + l);
        return r;
    endfunction

    task automatic clear_stats();
        cyc = 0; dk = 0; ak = 0;
        pumps = 0; data_reads = 0; acc_reads = 0; acc_stalls = 0; acc_ready_seen = 0;
        writes = 0; wlast_row = -1; wlast_err = 0; fin_cnt = 0; fin_cyc = -1; fin_id = '0;
        sw_cnt = 0; stall_cnt = 0; stall_pump_err = 0; stall_err = 0; stall_wd = '0;
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step();
        logic          pmp, wr;
        logic [RL-1:0] dm, am, wd;
        logic [2:0]    wa;
        logic [1:0]    wrow;
        data_rvalid_i = (dk < n_exp) ? (cyc >= d_off[dk]) : 1'b0;
        acc_rvalid_i  = (!zacc_t && ak < n_exp) ? (cyc >= a_off[ak]) : 1'b0;
        res_wready_i  = 1'b1;
        #1;
        if (res_we_o && int'(res_wrowaddr_o) == stall_row && stall_cnt < stall_len) res_wready_i = 1'b0;
        #1;
        if (switch_db_o) sw_cnt++;
        if (acc_rvalid_i && !acc_rready_o) acc_stalls++;
        if (acc_rready_o) acc_ready_seen++;
        if (data_rvalid_i && data_rready_o) begin dk++; data_reads++; end
        if (acc_rvalid_i && acc_rready_o) begin ak++; acc_reads++; end
        if (res_we_o && !res_wready_i) begin
            if (stall_cnt == 0) stall_wd = res_wdata_o;
            else if (res_wdata_o !== stall_wd || int'(res_wrowaddr_o) != stall_row) stall_err++;
            if (pump_o) stall_pump_err++;
            stall_cnt++;
        end
        pmp = pump_o; dm = data_mesh_o; am = acc_mesh_o;
        if (pump_o) pumps++;
        wr = res_we_o & res_wready_i; wa = res_waddr_o; wrow = res_wrowaddr_o; wd = res_wdata_o;
        if (wr) begin
            writes++;
            if (res_wlast_o !== (int'(res_wrowaddr_o) == n_exp - 1)) wlast_err++;
            if (res_wlast_o) wlast_row = int'(res_wrowaddr_o);
        end
        if (finished_o) begin fin_cnt++; fin_cyc = cyc; fin_id = finished_id_o; end
        @(posedge clk_i);
        #1;
        if (pmp) begin
            for (int s = MW - 1; s > 0; s--) mpipe[s] = mpipe[s-1];
            mpipe[0] = prod_row(dm, am);
        end
        if (wr) rf[wa][wrow] = wd;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic preset_res(input logic [2:0] rr);
        for (int r = 0; r < MW; r++) rf[rr][r] = sentinel(r);
    endtask

    task automatic issue(input logic [2:0] dr, input logic [2:0] ar, input logic [2:0] rr,
                         input logic [2:0] nr, input bit za, input logic [3:0] id, input int nexp);
        clear_stats();
        preset_res(rr);
        n_exp = nexp; zacc_t = za;
        issue_valid_i = 1'b1; data_reg_i = dr; acc_reg_i = ar; res_reg_i = rr;
        n_rows_i = nr; zero_acc_i = za; id_i = id;
        step();
        issue_valid_i = 1'b0;
    endtask

    task automatic run_tile(input logic [2:0] dr, input logic [2:0] ar, input logic [2:0] rr,
                            input logic [2:0] nr, input bit za, input logic [3:0] id, input int nexp);
        issue(dr, ar, rr, nr, za, id, nexp);
        while (fin_cnt == 0 && cyc < 60) step();
    endtask

    task automatic check_res(input string tag, input logic [2:0] dr, input logic [2:0] ar,
                             input logic [2:0] rr, input int nexp, input bit za);
        for (int r = 0; r < MW; r++)
            check($sformatf("%s_row%0d", tag, r), rf[rr][r],
                  (r < nexp) ? prod_row(rf[dr][r], za ? '0 : rf[ar][r]) : sentinel(r));
    endtask

    task automatic set_offsets(input int d0, input int d1, input int d2, input int d3,
                               input int a0, input int a1, input int a2, input int a3);
        d_off[0] = d0; d_off[1] = d1; d_off[2] = d2; d_off[3] = d3;
        a_off[0] = a0; a_off[1] = a1; a_off[2] = a2; a_off[3] = a3;
    endtask

    initial begin
        for (int g = 0; g < 8; g++)
            for (int r = 0; r < MW; r++)
                for (int l = 0; l < MW; l++) rf[g][r][l*DW +: DW] = 32'(g * 64 + r * 8 + l + 1);
        for (int s = 0; s < MW; s++) mpipe[s] = '0;
        stall_row = -1; stall_len = 0; n_exp = 0; zacc_t = 1'b0;
        set_offsets(1, 1, 1, 1, 1, 1, 1, 1);
        clear_stats();

        // Reset state
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_ready", 128'(issue_ready_o), 128'(1));
        check("rst_pump", 128'(pump_o), 128'(0));
        check("rst_we", 128'(res_we_o), 128'(0));
        check("rst_rready", 128'({data_rready_o, acc_rready_o}), 128'(0));
        check("rst_fin", 128'(finished_o), 128'(0));
        check("rst_mesh", data_mesh_o | acc_mesh_o, '0);
        check("rst_id", 128'({sa_id_o, finished_id_o}), 128'(0));

        // 1: full tile, both ports valid every cycle
        run_tile(3'd1, 3'd2, 3'd5, 3'd4, 1'b0, 4'd9, 4);
        check("t1_switch", 128'(sw_cnt), 128'(1));
        check("t1_fin_cyc", 128'(fin_cyc), 128'(12));
        check("t1_fin_id", 128'(fin_id), 128'(9));
        check("t1_sa_id", 128'(sa_id_o), 128'(9));
        check("t1_reads", 128'({data_reads[7:0], acc_reads[7:0]}), 128'(16'h0404));
        check("t1_pumps", 128'(pumps), 128'(11));
        check("t1_writes", 128'(writes), 128'(4));
        check("t1_wlast", 128'({wlast_row[7:0], wlast_err[7:0]}), 128'(16'h0300));
        check_res("t1", 3'd1, 3'd2, 3'd5, 4, 1'b0);

        // 2: ports out of step, holds absorb the skew
        set_offsets(1, 2, 3, 4, 3, 5, 6, 8);
        run_tile(3'd3, 3'd4, 3'd6, 3'd4, 1'b0, 4'd2, 4);
        check("t2_fin_cyc", 128'(fin_cyc), 128'(16));
        check("t2_acc_stalls", 128'(acc_stalls), 128'(0));
        check("t2_pumps", 128'(pumps), 128'(11));
        check_res("t2", 3'd3, 3'd4, 3'd6, 4, 1'b0);

        // 3: two rows, zero accumulator
        set_offsets(1, 1, 1, 1, 1, 1, 1, 1);
        run_tile(3'd1, 3'd2, 3'd7, 3'd2, 1'b1, 4'd5, 2);
        check("t3_acc_ready", 128'(acc_ready_seen), 128'(0));
        check("t3_data_reads", 128'(data_reads), 128'(2));
        check("t3_fin_cyc", 128'(fin_cyc), 128'(12));
        check("t3_pumps", 128'(pumps), 128'(11));
        check("t3_writes", 128'(writes), 128'(2));
        check("t3_wlast", 128'({wlast_row[7:0], wlast_err[7:0]}), 128'(16'h0100));
        check_res("t3", 3'd1, 3'd2, 3'd7, 2, 1'b1);

        // 4: write backpressure on row 1 for three cycles
        stall_row = 1; stall_len = 3;
        run_tile(3'd3, 3'd1, 3'd0, 3'd4, 1'b0, 4'd7, 4);
        stall_row = -1; stall_len = 0;
        check("t4_stall_cnt", 128'(stall_cnt), 128'(3));
        check("t4_stall_pump", 128'(stall_pump_err), 128'(0));
        check("t4_stall_hold", 128'(stall_err), 128'(0));
        check("t4_fin_cyc", 128'(fin_cyc), 128'(15));
        check_res("t4", 3'd3, 3'd1, 3'd0, 4, 1'b0);

        // 5: reset during FLUSH abandons the tile
        issue(3'd2, 3'd4, 3'd6, 3'd4, 1'b0, 4'd3, 4);
        while (pumps < 5 && cyc < 60) step();
        check("t5_in_flush", 128'(pumps), 128'(5));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check("t5_ready", 128'(issue_ready_o), 128'(1));
        check("t5_mesh_clear", data_mesh_o | acc_mesh_o, '0);
        n_exp = 0; writes = 0; fin_cnt = 0;
        for (int i = 0; i < 12; i++) step();
        check("t5_no_fin", 128'(fin_cnt), 128'(0));
        check("t5_no_write", 128'(writes), 128'(0));
        check("t5_res_untouched", rf[6][0], sentinel(0));

        // 6: n_rows 0 and 7 clamp to a full tile
        run_tile(3'd2, 3'd4, 3'd6, 3'd0, 1'b0, 4'd11, 4);
        check("t6a_fin_cyc", 128'(fin_cyc), 128'(12));
        check("t6a_writes", 128'(writes), 128'(4));
        check_res("t6a", 3'd2, 3'd4, 3'd6, 4, 1'b0);
        run_tile(3'd4, 3'd3, 3'd5, 3'd7, 1'b0, 4'd12, 4);
        check("t6b_fin_cyc", 128'(fin_cyc), 128'(12));
        check("t6b_writes", 128'(writes), 128'(4));
        check("t6b_wlast", 128'(wlast_row), 128'(3));
        check_res("t6b", 3'd4, 3'd3, 3'd5, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
